// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin arbiter sharing one circular LIFO between NUM_REQ requesters, with occupancy tracking and tagged pop responses.
// Ports: clk/reset (sync, active-high; reset the stack in the same cycle);
//   req_valid/req_op/req_data in, req_ready out (one-hot grant, combinational);
//   rsp_valid/rsp_id/rsp_data/rsp_err pop response two cycles after acceptance;
//   ovf_err one-cycle pulse on a dropped push; depth current occupancy 0..2**STACK_SIZE;
//   stk_push/stk_pop/stk_data_in to the stack, stk_data_out from the stack.
// Build option: define STACK_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module stack_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int STACK_WIDTH = 18,
  parameter int STACK_SIZE = 4,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_op,
  input  logic [NUM_REQ*STACK_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           rsp_valid,
  output logic [ID_W-1:0]                rsp_id,
  output logic [STACK_WIDTH-1:0]         rsp_data,
  output logic                           rsp_err,
  output logic                           ovf_err,
  output logic [STACK_SIZE:0]            depth,
  output logic                           stk_push,
  output logic                           stk_pop,
  output logic [STACK_WIDTH-1:0]         stk_data_in,
  input  logic [STACK_WIDTH-1:0]         stk_data_out
);
  localparam logic [STACK_SIZE:0] FULL = (STACK_SIZE+1)'(1) << STACK_SIZE;
  logic [ID_W-1:0] win;
  logic any, op, full, empty, do_push, do_pop;
  logic [STACK_WIDTH-1:0] data;
  logic p1_valid, p1_err;
  logic [ID_W-1:0] p1_id;
`ifdef STACK_ARB_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = NUM_REQ-1; k >= 0; k--) if (req_valid[k]) begin
      win = ID_W'(k);
      any = 1'b1;
    end
  end
`else
  logic [ID_W-1:0] rr_ptr;
  // Scanning downward lets the lowest offset from rr_ptr overwrite the others, so it wins.
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = NUM_REQ-1; k >= 0; k--) if (req_valid[(int'(rr_ptr)+k) % NUM_REQ]) begin
      win = ID_W'((int'(rr_ptr)+k) % NUM_REQ);
      any = 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (reset) rr_ptr <= '0;
    else if (any) rr_ptr <= (int'(win) == NUM_REQ-1) ? '0 : win + 1'b1;
`endif
  assign req_ready = any ? NUM_REQ'(1) << win : '0;
  assign op = req_op[win];
  assign data = req_data[int'(win)*STACK_WIDTH +: STACK_WIDTH];
  assign full = depth == FULL;
  assign empty = depth == '0;
  assign do_push = any & op & ~full;
  assign do_pop = any & ~op & ~empty;
  // Stack data is valid in the cycle after stk_pop, which is when the response is presented.
  assign rsp_data = rsp_valid & ~rsp_err ? stk_data_out : '0;
  always_ff @(posedge clk)
    if (reset) begin
      depth <= '0;
      stk_push <= 1'b0;
      stk_pop <= 1'b0;
      stk_data_in <= '0;
      ovf_err <= 1'b0;
      p1_valid <= 1'b0;
      p1_err <= 1'b0;
      p1_id <= '0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_id <= '0;
    end else begin
      depth <= do_push ? depth + 1'b1 : do_pop ? depth - 1'b1 : depth;
      stk_push <= do_push;
      stk_pop <= do_pop;
      stk_data_in <= do_push ? data : '0;
      ovf_err <= any & op & full;
      p1_valid <= any & ~op;
      p1_err <= any & ~op & empty;
      p1_id <= any & ~op ? win : '0;
      rsp_valid <= p1_valid;
      rsp_err <= p1_err;
      rsp_id <= p1_id;
    end
endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: randomized and directed bench for stack_arbiter against a queue-based reference model.
module tb_stack_arbiter;
  localparam int NR = 4, W = 18, SS = 2, DEPTH = 1 << SS;
  logic clk = 0, reset = 1;
  logic [NR-1:0] req_valid = 0, req_op = 0, req_ready;
  logic [NR*W-1:0] req_data = 0;
  logic rsp_valid, rsp_err, ovf_err, stk_push, stk_pop;
  logic [1:0] rsp_id;
  logic [W-1:0] rsp_data, stk_data_in, stk_data_out = 0;
  logic [SS:0] depth;
  int checks = 0, failures = 0;

  stack_arbiter #(.NUM_REQ(NR), .STACK_WIDTH(W), .STACK_SIZE(SS)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .ovf_err(ovf_err), .depth(depth), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_data_in(stk_data_in), .stk_data_out(stk_data_out));

  always #5 clk = ~clk;

  // Circular stack device: registered data_out on pop.
  logic [W-1:0] mem [DEPTH];
  int sp = 0;
  always @(posedge clk)
    if (reset) sp = 0;
    else if (stk_push) begin mem[sp] = stk_data_in; sp = (sp + 1) % DEPTH; end
    else if (stk_pop) begin sp = (sp + DEPTH - 1) % DEPTH; stk_data_out <= mem[sp]; end

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, a, e, $time);
    end
  endtask

  function automatic int pick(logic [NR-1:0] v, int rr);
    for (int k = 0; k < NR; k++) if (v[(rr + k) % NR]) return (rr + k) % NR;
    return -1;
  endfunction

  // Reference model: stack contents as a queue, expected outputs for the cycle after each edge.
  logic [W-1:0] vals[$];
  int m_rr = 0;
  bit armed = 0;
  bit e_push, e_pop, e_ovf, e_rv, e_rerr, p_v, p_err;
  int e_rid, p_id;
  logic [W-1:0] e_din, e_rdata, p_data;
  always @(posedge clk) begin
    if (reset) begin
      armed = 1; vals.delete(); m_rr = 0;
      {e_push, e_pop, e_ovf, e_rv, e_rerr, p_v, p_err} = '0;
      e_rid = 0; p_id = 0; e_din = 0; e_rdata = 0; p_data = 0;
    end else begin
      int w;
      e_rv = p_v; e_rid = p_id; e_rerr = p_err; e_rdata = p_data; p_v = 0;
      e_push = 0; e_pop = 0; e_ovf = 0; e_din = 0;
      w = pick(req_valid, m_rr);
      if (w >= 0) begin
        if (req_op[w]) begin
          if (vals.size() < DEPTH) begin
            e_din = req_data[w*W +: W]; vals.push_back(e_din); e_push = 1;
          end else e_ovf = 1;
        end else begin
          p_v = 1; p_id = w;
          if (vals.size() > 0) begin p_data = vals.pop_back(); p_err = 0; e_pop = 1; end
          else begin p_data = 0; p_err = 1; end
        end
`ifndef STACK_ARB_FIXED_PRIO_EN
        m_rr = (w + 1) % NR;
`endif
      end
    end
  end

  typedef struct {int id; int err; int data;} rsp_t;
  rsp_t rlog[$];
  int glog[$];
  int ovf_n = 0, pop_n = 0;
  always @(negedge clk) if (armed) begin
    int w;
    w = pick(req_valid, m_rr);
    chk("req_ready", req_ready, w >= 0 ? 32'(1) << w : 0);
    chk("stk_push", stk_push, e_push);
    chk("stk_pop", stk_pop, e_pop);
    chk("ovf_err", ovf_err, e_ovf);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("rsp_err", rsp_err, e_rv & e_rerr);
    chk("depth", depth, vals.size());
    if (e_push) chk("stk_data_in", stk_data_in, e_din);
    if (e_rv) begin chk("rsp_id", rsp_id, e_rid); chk("rsp_data", rsp_data, e_rdata); end
    if (rsp_valid) rlog.push_back('{int'(rsp_id), int'(rsp_err), int'(rsp_data)});
    if (|req_ready) for (int i = 0; i < NR; i++) if (req_ready[i]) glog.push_back(i);
    if (ovf_err) ovf_n++;
    if (stk_pop) pop_n++;
  end

  task automatic drive(logic [NR-1:0] v, logic [NR-1:0] op, logic [NR*W-1:0] d);
    @(posedge clk); #1;
    req_valid = v; req_op = op; req_data = d;
  endtask
  task automatic one(int i, bit push, logic [W-1:0] d);
    logic [NR*W-1:0] dd;
    dd = '0; dd[i*W +: W] = d;
    drive(NR'(1) << i, push ? NR'(1) << i : '0, dd);
  endtask
  task automatic idle(int n);
    repeat (n) drive('0, '0, '0);
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1; req_valid = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    rlog.delete(); glog.delete(); ovf_n = 0; pop_n = 0;
  endtask

  initial begin
    logic [NR*W-1:0] d;
    do_reset();
    chk("reset_depth", depth, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    // LIFO from a single requester.
    one(0, 1, 'h11); one(0, 1, 'h22); one(0, 1, 'h33);
    idle(1);
    chk("t1_depth3", depth, 3);
    one(0, 0, 0); one(0, 0, 0); one(0, 0, 0);
    idle(3);
    chk("t1_nrsp", rlog.size(), 3);
    if (rlog.size() == 3) begin
      chk("t1_r0", rlog[0].data, 'h33); chk("t1_r1", rlog[1].data, 'h22);
      chk("t1_r2", rlog[2].data, 'h11); chk("t1_id", rlog[2].id, 0);
    end
    chk("t1_depth0", depth, 0);
    // All requesters pushing their own index.
    do_reset();
    for (int i = 0; i < NR; i++) d[i*W +: W] = W'(i);
    repeat (5) drive('1, '1, d);
    idle(2);
    chk("t2_ngrant", glog.size(), 5);
    if (glog.size() == 5) begin
      chk("t2_g1", glog[1], 1); chk("t2_g3", glog[3], 3); chk("t2_g4", glog[4], 0);
    end
    chk("t2_ovf", ovf_n, 1);
    one(2, 0, 0); idle(3);
    chk("t2_pop", rlog.size() == 1 ? rlog[0].data : -1, 3);
    // Overflow boundary with pushes 1..5.
    do_reset();
    for (int i = 1; i <= 5; i++) one(0, 1, W'(i));
    idle(2);
    chk("t3_depth", depth, DEPTH);
    chk("t3_ovf", ovf_n, 1);
    one(0, 0, 0); idle(3);
    chk("t3_pop", rlog.size() == 1 ? rlog[0].data : -1, 4);
    // Underflow from requester 2.
    do_reset();
    one(2, 0, 0); idle(3);
    chk("t4_nrsp", rlog.size(), 1);
    if (rlog.size() == 1) begin
      chk("t4_err", rlog[0].err, 1); chk("t4_data", rlog[0].data, 0); chk("t4_id", rlog[0].id, 2);
    end
    chk("t4_stkpop", pop_n, 0);
    chk("t4_depth", depth, 0);
    // Back-to-back pops crossing empty.
    do_reset();
    one(0, 1, 'hA0); one(1, 0, 0); one(3, 0, 0); idle(3);
    chk("t5_nrsp", rlog.size(), 2);
    if (rlog.size() == 2) begin
      chk("t5_d0", rlog[0].data, 'hA0); chk("t5_e0", rlog[0].err, 0); chk("t5_i0", rlog[0].id, 1);
      chk("t5_e1", rlog[1].err, 1); chk("t5_i1", rlog[1].id, 3);
    end
    // Reset the cycle after a pop is accepted.
    do_reset();
    one(1, 1, 'h5); one(1, 0, 0);
    @(posedge clk); #1;
    reset = 1; req_valid = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    rlog.delete(); glog.delete();
    drive('1, '1, '0); idle(3);
    chk("t6_nrsp", rlog.size(), 0);
    chk("t6_grant", glog.size() > 0 ? glog[0] : -1, 0);
    chk("t6_depth", depth, 1);
    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      logic [NR*W-1:0] rd;
      for (int i = 0; i < NR; i++) rd[i*W +: W] = W'($urandom);
      if ($urandom_range(0, 199) == 0) do_reset();
      else drive(NR'($urandom_range(0, 15)), (c / 40) % 2 == 0 ? NR'($urandom | $urandom) : NR'($urandom & $urandom), rd);
    end
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
- Shares one circular LIFO stack between NUM_REQ requesters, one operation per cycle.
- Tracks occupancy so the circular stack never wraps silently: overflowing pushes are dropped and underflowing pops are reported as errors.
- Sits directly in front of the stack. Drives its push/pop/data_in and returns pop data to the requester that issued the pop, tagged with that requester's index.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- STACK_WIDTH, 18, word width.
- STACK_SIZE, 4, log2 of stack depth (DEPTH = 2**STACK_SIZE).
- ID_W, $clog2(NUM_REQ), width of the response id.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_op  in  NUM_REQ  per-requester op: 1=push, 0=pop.
- req_data  in  NUM_REQ*STACK_WIDTH  push data; requester i in bits [i*STACK_WIDTH +: STACK_WIDTH].
- req_ready  out  NUM_REQ  one-hot grant; combinational.
- rsp_valid  out  1  pop response valid.
- rsp_id  out  ID_W  index of the requester that issued the pop.
- rsp_data  out  STACK_WIDTH  popped word.
- rsp_err  out  1  pop response is an underflow.
- ovf_err  out  1  one-cycle pulse: a push was dropped.
- depth  out  STACK_SIZE+1  current occupancy, 0..DEPTH.
- stk_push  out  1  to stack push.
- stk_pop  out  1  to stack pop.
- stk_data_in  out  STACK_WIDTH  to stack data_in.
- stk_data_out  in  STACK_WIDTH  from stack data_out.

Behaviour:
- Reset values: all outputs 0; rr_ptr=0; depth=0; pipeline valids cleared.
- Reset must also be applied to the stack in the same cycle, so its pointer and depth stay consistent.
- Arbitration (round-robin):
  - Scan req_valid starting at index rr_ptr, wrapping modulo NUM_REQ.
  - The first set bit wins; req_ready is one-hot at that index; all zeros if no valid.
  - Acceptance = req_valid[i] & req_ready[i]; at most one per cycle.
  - On acceptance, rr_ptr <= (i+1) mod NUM_REQ; otherwise rr_ptr holds.
  - req_ready never depends on depth. Full/empty do not stall; they are error cases.
- Stage 1 (registered, cycle after acceptance at T, i.e. T+1):
  - Push with depth<DEPTH: stk_push=1, stk_data_in=granted data, depth+1.
  - Push with depth==DEPTH: no stack op, depth unchanged, ovf_err=1 at T+1.
  - Pop with depth>0: stk_pop=1, depth-1.
  - Pop with depth==0: no stack op, depth unchanged, marked underflow.
  - The depth update is committed at the T edge, so back-to-back requests see the correct depth.
  - stk_push and stk_pop are never asserted together.
- Stage 2 (pop response, T+2):
  - rsp_valid=1 for exactly one cycle with rsp_id = granted index.
  - Normal pop: rsp_data = stk_data_out, rsp_err=0.
  - Underflow pop: rsp_data=0, rsp_err=1.
  - Pushes never generate rsp_valid.
- Throughput: one request per cycle; pops accepted in consecutive cycles give consecutive rsp_valid cycles.
- Ordering: LIFO across all requesters; pop data is whatever is on top regardless of who pushed it.
- Boundaries:
  - depth saturates at DEPTH and 0; it never wraps.
  - A push at depth DEPTH-1 followed next cycle by another push: the second push overflows.
  - A pop at depth 0 immediately after the last valid pop returns rsp_err.
- Reset mid-operation: in-flight stage-1 and stage-2 entries are discarded; no rsp_valid or ovf_err after reset asserts.

Optional Feature:
- Macro: STACK_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index valid requester always wins and rr_ptr is removed.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- Single requester 0: push 0x11, 0x22, 0x33, then pop three times -> rsp_data 0x33, 0x22, 0x11 at accept+2 each; rsp_id=0; depth 3->0.
- All four req_valid held high, all pushes, data=i -> grants in order 0,1,2,3,0; rr_ptr wraps; depth increments by 1 per cycle.
- STACK_SIZE=2: five pushes 1..5 -> depth=4; ovf_err pulses once, one cycle after the fifth acceptance; a following pop returns 4.
- Pop at depth 0 from requester 2 -> rsp_valid, rsp_err=1, rsp_data=0, rsp_id=2; stk_pop never asserted; depth stays 0.
- Push 0xA0 then back-to-back pops from requesters 1 and 3 at depth 1 -> first response 0xA0 with rsp_err=0 and id 1; second response rsp_err=1 with id 3.
- Assert reset in the cycle after accepting a pop -> no rsp_valid afterward; depth=0; next push is granted to requester 0.
